// File: rtl/enc_8b10b_tx_ctrl.sv
// 8b/10b transmit sequencer: alignment burst, idle/comma insertion and running disparity.
// Define ENC8B10B_K_CHECK_EN to replace invalid K inputs by K30.7 and raise sticky k_err.
module enc_8b10b_tx_ctrl #(
    parameter int unsigned ALIGN_LEN    = 4,
    parameter int unsigned ALIGN_PERIOD = 1024,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_tdata,
    input  logic       s_tuser,
    input  logic       s_tvalid,
    output logic       s_tready,
    output logic [9:0] m_tdata,
    output logic       m_tvalid,
    input  logic       m_tready,
    output logic       rd,
    output logic       aligned,
    output logic       k_err
);

    localparam int unsigned AW = $clog2(ALIGN_LEN + 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(ALIGN_PERIOD - 1);
    localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_LEN - 1);

    typedef enum logic {StAlign, StData} state_e;

    // 5b/6b code for RD-, string order abcdei with a in the MSB
    function automatic logic [5:0] tab6(input logic [4:0] x, input logic k);
        logic [5:0] t;
        case (x)
            5'd0:  t = 6'b100111;
            5'd1:  t = 6'b011101;
            5'd2:  t = 6'b101101;
            5'd3:  t = 6'b110001;
            5'd4:  t = 6'b110101;
            5'd5:  t = 6'b101001;
            5'd6:  t = 6'b011001;
            5'd7:  t = 6'b111000;
            5'd8:  t = 6'b111001;
            5'd9:  t = 6'b100101;
            5'd10: t = 6'b010101;
            5'd11: t = 6'b110100;
            5'd12: t = 6'b001101;
            5'd13: t = 6'b101100;
            5'd14: t = 6'b011100;
            5'd15: t = 6'b010111;
            5'd16: t = 6'b011011;
            5'd17: t = 6'b100011;
            5'd18: t = 6'b010011;
            5'd19: t = 6'b110010;
            5'd20: t = 6'b001011;
            5'd21: t = 6'b101010;
            5'd22: t = 6'b011010;
            5'd23: t = 6'b111010;
            5'd24: t = 6'b110011;
            5'd25: t = 6'b100110;
            5'd26: t = 6'b010110;
            5'd27: t = 6'b110110;
            5'd28: t = k ? 6'b001111 : 6'b001110;
            5'd29: t = 6'b101110;
            5'd30: t = 6'b011110;
            default: t = 6'b101011;
        endcase
        return t;
    endfunction

    // Returns {rd_next, code} with code bit0 = a ... bit9 = j
    function automatic logic [10:0] encode(input logic [7:0] d, input logic k, input logic rd_in);
        logic [5:0] t6, s6;
        logic [3:0] t4, s4;
        logic       flip4, rd_mid, use_a7;
        logic [9:0] code;
        t6     = tab6(d[4:0], k);
        s6     = (rd_in && (($countones(t6) != 3) || d[4:0] == 5'd7)) ? ~t6 : t6;
        rd_mid = rd_in ^ ($countones(t6) != 3);
        use_a7 = rd_mid ? (d[4:0] == 5'd11 || d[4:0] == 5'd13 || d[4:0] == 5'd14)
                        : (d[4:0] == 5'd17 || d[4:0] == 5'd18 || d[4:0] == 5'd20);
        flip4 = 1'b1;
        if (k) begin
            case (d[7:5])
                3'd0: t4 = 4'b1011;
                3'd1: t4 = 4'b0110;
                3'd2: t4 = 4'b1010;
                3'd3: t4 = 4'b1100;
                3'd4: t4 = 4'b1101;
                3'd5: t4 = 4'b0101;
                3'd6: t4 = 4'b1001;
                default: t4 = 4'b0111;
            endcase
        end else begin
            case (d[7:5])
                3'd0: t4 = 4'b1011;
                3'd1: begin t4 = 4'b1001; flip4 = 1'b0; end
                3'd2: begin t4 = 4'b0101; flip4 = 1'b0; end
                3'd3: t4 = 4'b1100;
                3'd4: t4 = 4'b1101;
                3'd5: begin t4 = 4'b1010; flip4 = 1'b0; end
                3'd6: begin t4 = 4'b0110; flip4 = 1'b0; end
                default: t4 = use_a7 ? 4'b0111 : 4'b1110;
            endcase
        end
        s4 = (rd_mid && flip4) ? ~t4 : t4;
        for (int i = 0; i < 6; i++) code[i] = s6[5-i];
        for (int i = 0; i < 4; i++) code[6+i] = s4[3-i];
        return {rd_mid ^ ($countones(t4) != 2), code};
    endfunction

    state_e           state_q, state_d;
    logic [AW-1:0]    align_cnt_q, align_cnt_d;
    logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
    logic [9:0]       m_tdata_q, m_tdata_d;
    logic             m_tvalid_q, m_tvalid_d;
    logic             rd_q, rd_d;
    logic             load, comma_due, take;
    logic [7:0]       sym_d;
    logic             sym_k;
    logic [10:0]      enc;

`ifdef ENC8B10B_K_CHECK_EN
    logic k_bad, k_err_q;

    function automatic logic k_valid(input logic [7:0] d);
        return (d[4:0] == 5'd28) || (d[7:5] == 3'd7 &&
               (d[4:0] == 5'd23 || d[4:0] == 5'd27 || d[4:0] == 5'd29 || d[4:0] == 5'd30));
    endfunction
`endif

    always_comb begin
        load      = !m_tvalid_q || m_tready;
        comma_due = (ALIGN_PERIOD != 0) && (period_cnt_q == PERIOD_LAST);
        take      = load && (state_q == StData) && !comma_due;
        sym_k     = 1'b1;
        sym_d     = 8'hBC;
`ifdef ENC8B10B_K_CHECK_EN
        k_bad     = 1'b0;
`endif
        if (take && s_tvalid) begin
            sym_k = s_tuser;
            sym_d = s_tdata;
`ifdef ENC8B10B_K_CHECK_EN
            if (s_tuser && !k_valid(s_tdata)) begin
                sym_d = 8'hFE;
                k_bad = 1'b1;
            end
`endif
        end
        enc = encode(sym_d, sym_k, rd_q);

        state_d      = state_q;
        align_cnt_d  = align_cnt_q;
        period_cnt_d = period_cnt_q;
        m_tdata_d    = m_tdata_q;
        m_tvalid_d   = m_tvalid_q;
        rd_d         = rd_q;
        if (load) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = enc[9:0];
            rd_d       = enc[10];
            // Any K28.5 on the line restarts the comma spacing
            if (sym_k && sym_d == 8'hBC) begin
                period_cnt_d = '0;
            end else if (period_cnt_q != PERIOD_LAST) begin
                period_cnt_d = period_cnt_q + 1'b1;
            end
            if (state_q == StAlign) begin
                if (align_cnt_q == ALIGN_LAST) begin
                    state_d     = StData;
                    align_cnt_d = '0;
                end else begin
                    align_cnt_d = align_cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StAlign;
            align_cnt_q  <= '0;
            period_cnt_q <= '0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            rd_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            align_cnt_q  <= align_cnt_d;
            period_cnt_q <= period_cnt_d;
            m_tdata_q    <= m_tdata_d;
            m_tvalid_q   <= m_tvalid_d;
            rd_q         <= rd_d;
        end
    end

`ifdef ENC8B10B_K_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) k_err_q <= 1'b0;
        else     k_err_q <= k_err_q | k_bad;
    end
    assign k_err = k_err_q;
`else
    assign k_err = 1'b0;
`endif

    assign s_tready = take;
    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign rd       = rd_q;
    assign aligned  = (state_q == StData);

endmodule

// File: tb/tb_enc_8b10b_tx_ctrl.sv
// Directed-vector bench for enc_8b10b_tx_ctrl (ALIGN_LEN=4, ALIGN_PERIOD=8).
module tb_enc_8b10b_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_tdata;
    logic       s_tuser, s_tvalid, s_tready;
    logic [9:0] m_tdata;
    logic       m_tvalid, m_tready, rd, aligned, k_err;

    always #5 clk = ~clk;

    enc_8b10b_tx_ctrl #(
        .ALIGN_LEN   (4),
        .ALIGN_PERIOD(8),
        .CNT_W       (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_tdata (s_tdata),
        .s_tuser (s_tuser),
        .s_tvalid(s_tvalid),
        .s_tready(s_tready),
        .m_tdata (m_tdata),
        .m_tvalid(m_tvalid),
        .m_tready(m_tready),
        .rd      (rd),
        .aligned (aligned),
        .k_err   (k_err)
    );

`ifdef ENC8B10B_K_CHECK_EN
    localparam logic [7:0] KB = 8'h00;   // invalid K, becomes K30.7 (RD+ form)
    localparam logic [9:0] KC = 10'h3A1;
    localparam logic       KE = 1'b1;
`else
    localparam logic [7:0] KB = 8'h1C;   // K28.0, RD+ form
    localparam logic [9:0] KC = 10'h343;
    localparam logic       KE = 1'b0;
`endif

    typedef struct {
        logic       rst;
        logic [7:0] d;
        logic       u, v, mr;
        logic       sr, mv;
        logic [9:0] md;
        logic       rd, al, ke;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic add(input logic r, input logic [7:0] d, input logic u, input logic v,
                       input logic mr, input logic sr, input logic mv, input logic [9:0] md,
                       input logic erd, input logic al, input logic ke);
        vec_t x;
        x = '{r, d, u, v, mr, sr, mv, md, erd, al, ke};
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input int idx, input logic [9:0] act,
                       input logic [9:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at vector %0d: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic align_burst();
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h17C, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h283, 0, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h17C, 1, 0, 0);
        add(0, 8'h00, 0, 0, 1, 0, 1, 10'h283, 0, 1, 0);
    endtask

    initial begin
        int   pc;
        logic mrd;
        logic [9:0] exp_md;

        rst = 1'b1; s_tdata = '0; s_tuser = 0; s_tvalid = 0; m_tready = 1'b1;

        add(1, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        add(1, 8'h00, 0, 0, 1, 0, 0, 10'h000, 0, 0, 0);
        align_burst();
        add(0, 8'h00, 0, 0, 1, 1, 1, 10'h17C, 1, 1, 0);   // idles
        add(0, 8'h00, 0, 0, 1, 1, 1, 10'h283, 0, 1, 0);
        for (int i = 0; i < 7; i++) add(0, 8'hB5, 0, 1, 1, 1, 1, 10'h155, 0, 1, 0);
        add(0, 8'hB5, 0, 1, 1, 0, 1, 10'h17C, 1, 1, 0);   // periodic comma
        for (int i = 0; i < 3; i++) add(0, 8'hB5, 0, 1, 1, 1, 1, 10'h155, 1, 1, 0);
        for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 1, 0, 0, 1, 10'h155, 1, 1, 0);  // stall
        add(0, 8'h00, 0, 1, 1, 1, 1, 10'h346, 1, 1, 0);
        add(0, 8'hB5, 0, 1, 1, 1, 1, 10'h155, 1, 1, 0);
        add(0, 8'h00, 0, 0, 1, 1, 1, 10'h283, 0, 1, 0);   // idle resets spacing
        for (int i = 0; i < 7; i++) add(0, 8'hB5, 0, 1, 1, 1, 1, 10'h155, 0, 1, 0);
        add(0, 8'h00, 0, 1, 1, 0, 1, 10'h17C, 1, 1, 0);   // comma beats pending byte
        add(0, 8'h00, 0, 1, 1, 1, 1, 10'h346, 1, 1, 0);
        add(0, KB,    1, 1, 1, 1, 1, KC,      1, 1, KE);
        add(0, 8'h00, 0, 0, 1, 1, 1, 10'h283, 0, 1, KE);
        add(0, 8'h00, 0, 0, 0, 0, 1, 10'h283, 0, 1, KE);
        add(1, 8'h00, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0);   // reset while stalled
        align_burst();

        foreach (vecs[i]) begin
            rst = vecs[i].rst; s_tdata = vecs[i].d; s_tuser = vecs[i].u;
            s_tvalid = vecs[i].v; m_tready = vecs[i].mr;
            vectors++;
            #1;
            if (!vecs[i].rst) chk("s_tready", i, s_tready, vecs[i].sr);
            @(posedge clk);
            #1;
            chk("m_tvalid", i, m_tvalid, vecs[i].mv);
            chk("m_tdata", i, m_tdata, vecs[i].md);
            chk("rd", i, rd, vecs[i].rd);
            chk("aligned", i, aligned, vecs[i].al);
            chk("k_err", i, k_err, vecs[i].ke);
        end

        // Continuous D21.5 right after alignment: seven data symbols then one comma
        pc  = 0;
        mrd = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rst = 0; s_tdata = 8'hB5; s_tuser = 0; s_tvalid = 1; m_tready = 1;
            vectors++;
            #1;
            chk("stream s_tready", 100 + i, s_tready, (pc != 7));
            @(posedge clk);
            #1;
            if (pc == 7) begin
                exp_md = mrd ? 10'h283 : 10'h17C;
                mrd    = ~mrd;
                pc     = 0;
            end else begin
                exp_md = 10'h155;
                pc++;
            end
            chk("stream m_tdata", 100 + i, m_tdata, exp_md);
            chk("stream rd", 100 + i, rd, mrd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enc_8b10b_tx_ctrl.md
Name: enc_8b10b_tx_ctrl

Overview:
- Transmit-side sequencer around the combinational enc_8b10b encoder.
- Accepts bytes on a valid/ready stream and owns the running-disparity register.
- Emits one registered 10-bit symbol per accepted output handshake.
- Inserts K28.5 alignment bursts after reset, K28.5 idles when no data is offered, and periodic K28.5 commas. Sits between framing logic and the serializer.

Parameters:
- ALIGN_LEN, 4, number of K28.5 symbols sent after reset before data is accepted (>=1).
- ALIGN_PERIOD, 1024, maximum symbols between K28.5 commas; 0 disables periodic insertion.
- CNT_W, 16, width of the period counter; must satisfy ALIGN_PERIOD < 2**CNT_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_tdata  in  8  byte to encode
- s_tuser  in  1  1 = control (K) character
- s_tvalid  in  1  input valid
- s_tready  out  1  input ready
- m_tdata  out  10  encoded symbol, bit0 = a ... bit9 = j, same ordering as enc_8b10b code_10b
- m_tvalid  out  1  symbol valid
- m_tready  in  1  serializer ready
- rd  out  1  current running disparity (0 = RD-, 1 = RD+)
- aligned  out  1  1 when in state DATA
- k_err  out  1  sticky invalid-K flag (optional feature)

Behaviour:
- Interface: one clock; reset is synchronous and active-high, clock port clk, reset port rst.
- Reset values: m_tvalid=0, m_tdata=0, rd=0, state=ALIGN, align_cnt=0, period_cnt=0, k_err=0, s_tready=0.
- Output stage:
  - load = !m_tvalid | m_tready.
  - On load the stage captures the encoder output for the selected symbol, using disp = rd; rd <= disp_next. m_tvalid <= 1 once past reset.
  - rd changes only on load. m_tdata and rd are held stable while m_tvalid & !m_tready.
- Latency: s_tvalid & s_tready at cycle N gives m_tdata valid at N+1.
- Symbol select, evaluated each load:
  - ALIGN: send K28.5 (8'hBC, K=1). align_cnt++; on reaching ALIGN_LEN, go to DATA and clear align_cnt.
  - DATA, comma_due: send K28.5 and hold s_tready=0. comma_due = (ALIGN_PERIOD != 0) & (period_cnt == ALIGN_PERIOD-1).
  - DATA, s_tvalid: send {s_tuser, s_tdata}.
  - DATA, !s_tvalid: send K28.5 idle.
- s_tready = load & (state==DATA) & !comma_due. It is purely combinational from m_tready and state; there is no skid buffer.
- period_cnt:
  - Clears to 0 whenever a K28.5 (alignment, comma or idle) is loaded.
  - Otherwise increments on each loaded data symbol, saturating at ALIGN_PERIOD-1.
  - A user-supplied K28.5 also clears it.
- No state transition other than reset returns to ALIGN.
- Reset mid-operation: any held symbol is dropped, rd returns to RD-, and the alignment burst restarts.
- Simultaneous comma_due & s_tvalid: the comma wins; the input byte waits with s_tready=0 and is taken on the next load.
- No input combinational paths to m_tdata; all outputs except s_tready are registered.

Optional Feature:
- Macro: ENC8B10B_K_CHECK_EN.
- Defined:
  - A K input other than K28.0–K28.7, K23.7, K27.7, K29.7 or K30.7 is accepted but encoded as K30.7 (8'hFE, K=1).
  - k_err is set, sticky until rst.
- Undefined: K inputs pass to the encoder unchecked; k_err is tied 0.

Test Plan:
1. Reset release with m_tready=1, s_tvalid=0, ALIGN_LEN=4 -> m_tdata = 0x17C, 0x283, 0x17C, 0x283; then idle 0x17C... continues alternating. s_tready=0 for the first 4 symbols; aligned=1 from symbol 5; rd toggles every symbol.
2. After alignment with rd=0, stream 8'hB5 (D21.5) x10 -> m_tdata=0x155 each, rd stays 0, one input accepted per cycle, latency 1.
3. Backpressure: m_tready=0 for 5 cycles mid-stream -> m_tdata and rd are held, s_tready=0. Resume -> no byte is lost or duplicated.
4. ALIGN_PERIOD=8, continuous D21.5 -> 7 data symbols (0x155), then a K28.5 with s_tready low for that cycle, repeating. Idle gaps reset the spacing.
5. rst asserted for 1 cycle mid-stream with m_tready=0 -> the next cycle gives m_tvalid=0 and rd=0, then the ALIGN burst restarts from 0x17C.
6. With ENC8B10B_K_CHECK_EN, send K=1 byte 8'h00 -> K30.7 is emitted, k_err=1 and stays set. Without the macro, K28.0's code is emitted (via 8'h1C) and k_err stays 0.
